// File: rtl/shift_pkg.sv
// Shared definitions for the single-position shifter bank.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package shift_pkg;

  // Default operand width and shift distance.
  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_SHAMT = 1;

  // Number of parallel operations the bank produces.
  localparam int NUM_OPS = 5;

  // Operation index: selects which shift/rotate variant shift_core returns.
  typedef enum logic [2:0] {
    SHL = 3'd0,  // logical shift left, zero fill
    SHR = 3'd1,  // logical shift right, zero fill
    SAR = 3'd2,  // arithmetic shift right, sign fill
    ROL = 3'd3,  // rotate left
    ROR = 3'd4   // rotate right
  } shift_op_e;

endpackage : shift_pkg

// File: rtl/shift_core.sv
// Combinational fixed-distance shift/rotate of one operand, operation chosen by op.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input continuously.
module shift_core
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SHAMT = DEFAULT_SHAMT
) (
  input  logic [WIDTH-1:0] a,
  input  shift_op_e        op,
  output logic [WIDTH-1:0] y
);

  // Slices are written as explicit concatenations so every result is exactly
  // WIDTH bits and X/Z bits on a travel through untouched.
  always_comb begin
    y = '0;
    case (op)
      SHL:     y = {a[WIDTH-1-SHAMT:0], {SHAMT{1'b0}}};
      SHR:     y = {{SHAMT{1'b0}}, a[WIDTH-1:SHAMT]};
      SAR:     y = {{SHAMT{a[WIDTH-1]}}, a[WIDTH-1:SHAMT]};
      ROL:     y = {a[WIDTH-1-SHAMT:0], a[WIDTH-1:WIDTH-SHAMT]};
      ROR:     y = {a[SHAMT-1:0], a[WIDTH-1:SHAMT]};
      default: y = '0;
    endcase
  end

endmodule : shift_core

// File: rtl/shift_unit.sv
// Registered bank of five one-position shift/rotate variants of operand a.
// Latency: 1 cycle; a new operand is accepted every cycle.
// Backpressure: none; no handshake, outputs always reflect the last captured a.
module shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SHAMT = DEFAULT_SHAMT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [WIDTH-1:0] y4,
  output logic [WIDTH-1:0] y5
);

  logic [WIDTH-1:0] res_shl;
  logic [WIDTH-1:0] res_shr;
  logic [WIDTH-1:0] res_sar;
  logic [WIDTH-1:0] res_rol;
  logic [WIDTH-1:0] res_ror;

  // One core per operation; op is tied off so each instance reduces to wiring.
  shift_core #(.WIDTH(WIDTH), .SHAMT(SHAMT)) u_shl (.a(a), .op(SHL), .y(res_shl));
  shift_core #(.WIDTH(WIDTH), .SHAMT(SHAMT)) u_shr (.a(a), .op(SHR), .y(res_shr));
  shift_core #(.WIDTH(WIDTH), .SHAMT(SHAMT)) u_sar (.a(a), .op(SAR), .y(res_sar));
  shift_core #(.WIDTH(WIDTH), .SHAMT(SHAMT)) u_rol (.a(a), .op(ROL), .y(res_rol));
  shift_core #(.WIDTH(WIDTH), .SHAMT(SHAMT)) u_ror (.a(a), .op(ROR), .y(res_ror));

  // Capture all five results together; reset clears them without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y1 <= '0;
      y2 <= '0;
      y3 <= '0;
      y4 <= '0;
      y5 <= '0;
    end else begin
      y1 <= res_shl;
      y2 <= res_shr;
      y3 <= res_sar;
      y4 <= res_rol;
      y5 <= res_ror;
    end
  end

endmodule : shift_unit

// File: tb/tb_shift_unit.sv
// Directed and streaming checks of the registered shifter bank at WIDTH=8, SHAMT=1.
// Latency expected: results of a captured at a rising edge are visible after it.
// Backpressure: none; inputs driven and outputs sampled on falling edges.
module tb_shift_unit;

  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] y1, y2, y3, y4, y5;

  int n_checks = 0;
  int n_fail   = 0;

  shift_unit #(.WIDTH(8), .SHAMT(1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .y1   (y1),
    .y2   (y2),
    .y3   (y3),
    .y4   (y4),
    .y5   (y5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Independent bitwise reference, written per output bit.
  task automatic model(input logic [7:0] v, output logic [7:0] e1, output logic [7:0] e2,
                       output logic [7:0] e3, output logic [7:0] e4, output logic [7:0] e5);
    for (int i = 0; i < 8; i++) begin
      e1[i] = (i >= 1) ? v[i-1] : 1'b0;
      e2[i] = (i <= 6) ? v[i+1] : 1'b0;
      e3[i] = (i <= 6) ? v[i+1] : v[7];
      e4[i] = v[(i+7)%8];
      e5[i] = v[(i+1)%8];
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e1, input logic [7:0] e2,
                         input logic [7:0] e3, input logic [7:0] e4, input logic [7:0] e5);
    chk({tag, ".y1"}, y1, e1);
    chk({tag, ".y2"}, y2, e2);
    chk({tag, ".y3"}, y3, e3);
    chk({tag, ".y4"}, y4, e4);
    chk({tag, ".y5"}, y5, e5);
  endtask

  // Hand-computed directed vectors: operand and y1..y5.
  logic [7:0] vec [5][6];
  initial begin
    vec[0] = '{8'hF0, 8'hE0, 8'h78, 8'hF8, 8'hE1, 8'h78};
    vec[1] = '{8'h81, 8'h02, 8'h40, 8'hC0, 8'h03, 8'hC0};
    vec[2] = '{8'h01, 8'h02, 8'h00, 8'h00, 8'h02, 8'h80};
    vec[3] = '{8'hFF, 8'hFE, 8'h7F, 8'hFF, 8'hFF, 8'hFF};
    vec[4] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  end

  initial begin
    logic [7:0] prev, nxt;
    logic [7:0] e1, e2, e3, e4, e5;

    rst_n = 1'b1;
    a     = 8'hF0;
    #1 rst_n = 1'b0;

    // Held in reset while a toggles across several rising edges.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_all($sformatf("reset_hold%0d", i), 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      a = (i % 2 == 0) ? 8'h0F : 8'hF0;
    end

    // Release away from the clock edge; first capture is the first directed vector.
    a     = vec[0][0];
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_all($sformatf("dir_%02h", vec[i][0]), vec[i][1], vec[i][2], vec[i][3], vec[i][4], vec[i][5]);
      if (i < 4) a = vec[i+1][0];
    end

    // Load a nonzero result, then assert reset mid-cycle: outputs must clear before clk rises.
    a = 8'h81;
    @(negedge clk);
    chk("pre_reset.y3", y3, 8'hC0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_clear", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    chk("reset_discard.y4", y4, 8'h00);

    // Random streaming, operand changed every cycle; first check is the first capture after release.
    prev  = 8'($urandom);
    a     = prev;
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      model(prev, e1, e2, e3, e4, e5);
      chk_all($sformatf("stream%0d_a%02h", i, prev), e1, e2, e3, e4, e5);
      case (i % 10)
        3:       nxt = 8'h01;
        7:       nxt = 8'h00;
        9:       nxt = 8'h80;
        default: nxt = 8'($urandom_range(0, 255));
      endcase
      a    = nxt;
      prev = nxt;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_shift_unit
